// File: rtl/bt_cmd_pkg.sv
// Shared constants and types for the Bluetooth command-frame decoder.
// Opcodes, ACK/NAK bytes and the frame FSM state encoding.
package bt_cmd_pkg;

   localparam logic [7:0] HEADER_DEF  = 8'hA5;

   localparam logic [7:0] OP_BUZZ_ON  = 8'h01;
   localparam logic [7:0] OP_BUZZ_OFF = 8'h02;
   localparam logic [7:0] OP_SET_THR  = 8'h03;
   localparam logic [7:0] OP_ARM      = 8'h04;
   localparam logic [7:0] OP_PING     = 8'h05;

   localparam logic [7:0] ACK_BYTE    = 8'h06;
   localparam logic [7:0] NAK_BYTE    = 8'h15;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMD  = 2'd1,
      S_ARG  = 2'd2,
      S_CHK  = 2'd3
   } state_t;

   function automatic logic op_known(input logic [7:0] op);
      return (op >= OP_BUZZ_ON) && (op <= OP_PING);
   endfunction

endpackage

// File: rtl/cycle_timer.sv
// Saturating cycle counter: flags when MAX-1 is reached, then holds.
// Used for the inter-byte timeout and the optional link watchdog.
module cycle_timer #(
   parameter int MAX = 16
) (
   input  logic Clock,
   input  logic Reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int W = (MAX > 1) ? $clog2(MAX) : 1;

   logic [W-1:0] cnt;

   assign expired = (cnt == W'(MAX - 1));

   // count while enabled, clear has priority, hold once expired
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !expired) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/bt_cmd_parser.sv
// Bluetooth command-frame decoder: HEADER, CMD, ARG, CHK with CHK=CMD^ARG.
// Optional link-loss watchdog enabled by defining BTCMD_WATCHDOG_EN.
module bt_cmd_parser
   import bt_cmd_pkg::*;
#(
   parameter logic [7:0] HEADER       = HEADER_DEF,
   parameter int         BYTE_TIMEOUT = 5_000_000,
   parameter logic [7:0] THRESH_RST   = 8'h40,
   parameter int         WDOG_CYCLES  = 500_000_000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       rx_arrived,
   input  logic [7:0] rx_data,
   output logic       buzz_n,
   output logic       armed,
   output logic [7:0] illum_thresh,
   output logic       cmd_strobe,
   output logic       err_strobe,
   output logic [7:0] err_count,
   output logic       ack_trig,
   output logic [7:0] ack_byte,
   output logic       link_lost
);

   state_t     state;
   logic [7:0] cmd_q;
   logic [7:0] arg_q;
   logic       buzz_q;
   logic       tmo_expired;
   logic       byte_to;
   logic       in_frame;
   logic       chk_ok;
   logic       accept;

   assign in_frame = (state != S_IDLE);
   assign byte_to  = tmo_expired && in_frame && !rx_arrived;
   assign chk_ok   = (rx_data == (cmd_q ^ arg_q)) && op_known(cmd_q);
   assign accept   = rx_arrived && (state == S_CHK) && chk_ok;

   cycle_timer #(.MAX(BYTE_TIMEOUT)) u_byte_tmr (
      .Clock   (Clock),
      .Reset   (Reset),
      .clr     (rx_arrived || !in_frame),
      .en      (in_frame),
      .expired (tmo_expired)
   );

   // frame FSM with registered command state, strobes and ack
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state        <= S_IDLE;
         cmd_q        <= '0;
         arg_q        <= '0;
         buzz_q       <= 1'b1;
         armed        <= 1'b0;
         illum_thresh <= THRESH_RST;
         cmd_strobe   <= 1'b0;
         err_strobe   <= 1'b0;
         err_count    <= '0;
         ack_trig     <= 1'b0;
         ack_byte     <= ACK_BYTE;
      end else begin
         cmd_strobe <= 1'b0;
         err_strobe <= 1'b0;
         ack_trig   <= 1'b0;
         if (rx_arrived) begin
            unique case (state)
               S_IDLE: begin
                  if (rx_data == HEADER) state <= S_CMD;
               end
               S_CMD: begin
                  cmd_q <= rx_data;
                  state <= S_ARG;
               end
               S_ARG: begin
                  arg_q <= rx_data;
                  state <= S_CHK;
               end
               S_CHK: begin
                  state    <= S_IDLE;
                  ack_trig <= 1'b1;
                  if (chk_ok) begin
                     cmd_strobe <= 1'b1;
                     ack_byte   <= ACK_BYTE;
                     unique case (cmd_q)
                        OP_BUZZ_ON:  buzz_q       <= 1'b0;
                        OP_BUZZ_OFF: buzz_q       <= 1'b1;
                        OP_SET_THR:  illum_thresh <= arg_q;
                        OP_ARM:      armed        <= arg_q[0];
                        default:     ;
                     endcase
                  end else begin
                     err_strobe <= 1'b1;
                     ack_byte   <= NAK_BYTE;
                     if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end else if (byte_to) begin
            state      <= S_IDLE;
            cmd_q      <= '0;
            arg_q      <= '0;
            err_strobe <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
         end
      end
   end

`ifdef BTCMD_WATCHDOG_EN
   logic wd_expired;
   logic lost_q;

   cycle_timer #(.MAX(WDOG_CYCLES)) u_wdog (
      .Clock   (Clock),
      .Reset   (Reset),
      .clr     (cmd_strobe || !armed),
      .en      (1'b1),
      .expired (wd_expired)
   );

   // latch link loss; any accepted command clears it first
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         lost_q <= 1'b0;
      end else if (accept) begin
         lost_q <= 1'b0;
      end else if (wd_expired && armed && !cmd_strobe) begin
         lost_q <= 1'b1;
      end
   end

   assign link_lost = lost_q;
   assign buzz_n    = buzz_q && !lost_q;
`else
   logic unused_accept;
   assign unused_accept = accept;
   assign link_lost = 1'b0 & (WDOG_CYCLES > 0);
   assign buzz_n    = buzz_q;
`endif

endmodule
